// File: rtl/relu_mask_stream.sv
// +--------------------------------------------------------------------------+
// | relu_mask_stream : streaming ReLU forward pass with mask-gated backward   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module relu_mask_stream #(
  parameter int M = 5,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         z_valid,
  output logic         z_ready,
  input  logic [W-1:0] z,
  input  logic         da_valid,
  output logic         da_ready,
  input  logic [W-1:0] da,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         phase
);

  localparam int c_IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(M - 1);

  typedef enum logic [0:0] {
    FWD = 1'b0,
    BWD = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_IW-1:0] r_idx, w_idx_nxt;
  logic [M-1:0]    r_mask, w_mask_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic [W-1:0]    r_out_data, w_out_data_nxt;
  logic            r_out_last, w_out_last_nxt;

  logic w_can_accept;
  logic w_z_xfer;
  logic w_da_xfer;
  logic w_last_elem;
  logic w_z_pos;

  // A new element may enter whenever the output slot is empty or being drained.
  assign w_can_accept = !flush && (!r_out_valid || out_ready);
  assign z_ready      = (r_state == FWD) && w_can_accept;
  assign da_ready     = (r_state == BWD) && w_can_accept;
  assign w_z_xfer     = z_valid && z_ready;
  assign w_da_xfer    = da_valid && da_ready;
  assign w_last_elem  = (r_idx == c_LAST);
  assign w_z_pos      = !z[W-1] && (|z);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign phase     = (r_state == BWD);

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_mask_nxt      = r_mask;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    if (flush) begin
      w_state_nxt     = FWD;
      w_idx_nxt       = '0;
      w_mask_nxt      = '0;
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end else if (w_z_xfer || w_da_xfer) begin
      w_out_valid_nxt = 1'b1;
      if (w_z_xfer) begin
        w_out_data_nxt    = z[W-1] ? '0 : z;
        w_mask_nxt[r_idx] = w_z_pos;
      end else begin
        w_out_data_nxt = r_mask[r_idx] ? da : '0;
      end
      if (w_last_elem) begin
        w_idx_nxt      = '0;
        w_out_last_nxt = 1'b1;
        w_state_nxt    = (r_state == FWD) ? BWD : FWD;
      end else begin
        w_idx_nxt      = r_idx + c_IW'(1);
        w_out_last_nxt = 1'b0;
      end
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= FWD;
      r_idx       <= '0;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_mask      <= w_mask_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_relu_mask_stream.sv
// +--------------------------------------------------------------------------+
// | tb_relu_mask_stream : directed self-checking bench for relu_mask_stream   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_relu_mask_stream;

  localparam int M = 5;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         z_valid = 1'b0;
  logic         z_ready;
  logic [W-1:0] z = '0;
  logic         da_valid = 1'b0;
  logic         da_ready;
  logic [W-1:0] da = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         phase;

  int checks = 0;
  int errors = 0;

  relu_mask_stream #(.M(M), .W(W)) dut (
    .clk(clk), .reset(reset),
    .z_valid(z_valid), .z_ready(z_ready), .z(z),
    .da_valid(da_valid), .da_ready(da_ready), .da(da),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1; z_valid = 1'b1; z = 16'd5;
    tick(); tick();
    z_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b want 0", out_last); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL reset_phase got %0b want 0", phase); end
    checks++; if (z_ready !== 1'b1) begin errors++; $display("FAIL reset_z_ready got %0b want 1", z_ready); end
    checks++; if (da_ready !== 1'b0) begin errors++; $display("FAIL reset_da_ready got %0b want 0", da_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    logic [W-1:0] vin [5];
    logic [W-1:0] exp [5];
    vin = '{16'd3, 16'hFFFE, 16'd0, 16'd7, 16'hFFFF};
    exp = '{16'd3, 16'd0, 16'd0, 16'd7, 16'd0};
    for (int i = 0; i < 5; i++) begin
      z_valid = 1'b1; z = vin[i]; da_valid = 1'b1; da = 16'd99;
      #1;
      checks++; if (z_ready !== 1'b1) begin errors++; $display("FAIL fwd_z_ready[%0d] got %0b want 1", i, z_ready); end
      checks++; if (da_ready !== 1'b0) begin errors++; $display("FAIL fwd_da_ignored[%0d] got %0b want 0", i, da_ready); end
      tick();
      z_valid = 1'b0; da_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL fwd_out[%0d] got v=%0b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp[i]); end
      checks++; if (out_last !== (i == 4)) begin errors++; $display("FAIL fwd_last[%0d] got %0b want %0b", i, out_last, (i == 4)); end
    end
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL fwd_phase_after got %0b want 1", phase); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backward();
    logic [W-1:0] vin [5];
    logic [W-1:0] exp [5];
    vin = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    exp = '{16'd10, 16'd0, 16'd0, 16'd40, 16'd0};
    for (int i = 0; i < 5; i++) begin
      da_valid = 1'b1; da = vin[i]; z_valid = 1'b1; z = 16'd77;
      #1;
      checks++; if (da_ready !== 1'b1 || z_ready !== 1'b0) begin errors++; $display("FAIL bwd_ready[%0d] got da=%0b z=%0b want da=1 z=0", i, da_ready, z_ready); end
      tick();
      da_valid = 1'b0; z_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL bwd_out[%0d] got v=%0b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp[i]); end
      checks++; if (out_last !== (i == 4)) begin errors++; $display("FAIL bwd_last[%0d] got %0b want %0b", i, out_last, (i == 4)); end
    end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL bwd_phase_after got %0b want 0", phase); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vin [5];
    logic [W-1:0] exp [5];
    logic [W-1:0] dvin [5];
    logic [W-1:0] dexp [5];
    vin  = '{16'd5, 16'hFFFC, 16'd6, 16'd1, 16'd2};
    exp  = '{16'd5, 16'd0, 16'd6, 16'd1, 16'd2};
    dvin = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    dexp = '{16'd1, 16'd0, 16'd3, 16'd4, 16'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      z_valid = 1'b1; z = vin[i];
      if (i == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          checks++; if (z_ready !== 1'b0) begin errors++; $display("FAIL bp_z_ready[%0d] got %0b want 0", s, z_ready); end
          tick();
          checks++; if (out_valid !== 1'b1 || out_data !== 16'd0 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%0b d=%0d l=%0b want v=1 d=0 l=0", s, out_valid, out_data, out_last); end
        end
        out_ready = 1'b1;
      end
      #1;
      checks++; if (z_ready !== 1'b1) begin errors++; $display("FAIL bp_z_ready_go[%0d] got %0b want 1", i, z_ready); end
      tick();
      z_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 4)) begin errors++; $display("FAIL bp_out[%0d] got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", i, out_valid, out_data, out_last, exp[i], (i == 4)); end
    end
    for (int i = 0; i < 5; i++) begin
      da_valid = 1'b1; da = dvin[i];
      tick();
      da_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== dexp[i] || out_last !== (i == 4)) begin errors++; $display("FAIL bp_bwd_out[%0d] got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", i, out_valid, out_data, out_last, dexp[i], (i == 4)); end
    end
    tick();
  endtask

  task automatic test_flush();
    logic [W-1:0] vneg [5];
    vneg = '{16'hFFFF, 16'hFFFB, 16'd0, 16'hFFFD, 16'hFFF8};
    for (int i = 0; i < 5; i++) begin
      z_valid = 1'b1; z = W'(i + 1);
      tick();
    end
    z_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      da_valid = 1'b1; da = 16'd33;
      tick();
    end
    checks++; if (out_data !== 16'd33) begin errors++; $display("FAIL flush_pre_da got %0d want 33", out_data); end
    flush = 1'b1;
    #1;
    checks++; if (da_ready !== 1'b0 || z_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got da=%0b z=%0b want 0 0", da_ready, z_ready); end
    tick();
    flush = 1'b0; da_valid = 1'b0;
    checks++; if (phase !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL flush_state got p=%0b v=%0b l=%0b want 0 0 0", phase, out_valid, out_last); end
    for (int i = 0; i < 5; i++) begin
      z_valid = 1'b1; z = vneg[i];
      tick();
      z_valid = 1'b0;
      checks++; if (out_data !== 16'd0 || out_last !== (i == 4)) begin errors++; $display("FAIL flush_fwd[%0d] got d=%0d l=%0b want d=0 l=%0b", i, out_data, out_last, (i == 4)); end
    end
    for (int i = 0; i < 5; i++) begin
      da_valid = 1'b1; da = 16'd7;
      tick();
      da_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'd0) begin errors++; $display("FAIL flush_bwd[%0d] got v=%0b d=%0d want v=1 d=0", i, out_valid, out_data); end
    end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL flush_bwd_phase got %0b want 0", phase); end
    tick();
  endtask

  task automatic test_reset_mid_pass();
    logic [W-1:0] vin [5];
    logic [W-1:0] exp [5];
    vin = '{16'd2, 16'hFFFD, 16'd8, 16'd0, 16'd1};
    exp = '{16'd2, 16'd0, 16'd8, 16'd0, 16'd1};
    for (int i = 0; i < 3; i++) begin
      z_valid = 1'b1; z = 16'd9;
      tick();
    end
    reset = 1'b0; flush = 1'b1;
    tick();
    reset = 1'b1; flush = 1'b0; z_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0 || phase !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%0b d=%0d l=%0b p=%0b want 0 0 0 0", out_valid, out_data, out_last, phase); end
    for (int i = 0; i < 5; i++) begin
      z_valid = 1'b1; z = vin[i];
      tick();
      z_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 4)) begin errors++; $display("FAIL rst_fwd[%0d] got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", i, out_valid, out_data, out_last, exp[i], (i == 4)); end
    end
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL rst_fwd_phase got %0b want 1", phase); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_forward();
    test_backward();
    test_backpressure();
    test_flush();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
